// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and types for the architectural register file
package regfile_pkg;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 64;
    localparam int ZERO_REG  = 31;
    typedef logic [DATA_W-1:0]    word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/dec_5to32.sv
// dec_5to32: one-hot write-enable decoder gated by write_enable
module dec_5to32
    import regfile_pkg::*;
(
    input  logic                write_enable,
    input  logic [4:0]          sel,
    output logic [NUM_REGS-1:0] en
);
    // exactly one enable high when writing, none otherwise
    always_comb en = write_enable ? (NUM_REGS'(1) << sel) : '0;
endmodule

// File: rtl/reg_word.sv
// reg_word: one WIDTH-bit register with load enable and synchronous reset
module reg_word #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] val_d, val_q;
    // hold unless loading
    always_comb val_d = en ? d : val_q;
    // reset has priority over a same-edge load
    always_ff @(posedge clk) begin
        if (reset) val_q <= '0;
        else       val_q <= val_d;
    end
    assign q = val_q;
endmodule

// File: rtl/regfile_bypass.sv
// regfile_bypass: 32x64 register file, hardwired zero register, write-to-read bypass
module regfile_bypass #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);
    import regfile_pkg::*;

    localparam reg_idx_t ZR = reg_idx_t'(ZERO_REG);

    logic [NUM_REGS-1:0] we;
    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic                byp1, byp2;

    dec_5to32 u_dec (
        .write_enable (RegWrite),
        .sel          (WriteRegister),
        .en           (we)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == ZERO_REG) begin : g_zero
            assign regs[g] = '0;
        end else begin : g_store
            reg_word #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .reset (reset),
                .en    (we[g]),
                .d     (WriteData),
                .q     (regs[g])
            );
        end
    end

    // bypass when the decoder enables the register being read, never for XZR; reset forces zero
    always_comb begin
        byp1      = we[ReadRegister1] && (ReadRegister1 != ZR);
        byp2      = we[ReadRegister2] && (ReadRegister2 != ZR);
        ReadData1 = reset ? '0 : byp1 ? WriteData : regs[ReadRegister1];
        ReadData2 = reset ? '0 : byp2 ? WriteData : regs[ReadRegister2];
    end
endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: directed vectors with queue-based scoreboard for regfile_bypass
module tb_regfile_bypass;
    typedef struct {
        logic [63:0] e1;
        logic [63:0] e2;
        string       name;
    } exp_t;

    logic        clk = 1'b1;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister, ReadRegister1, ReadRegister2;
    logic [63:0] WriteData, ReadData1, ReadData2;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    regfile_bypass #(.WIDTH(64), .ZERO_REG(31)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    // monitor: outputs are combinational, so every cycle presents a response at mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (ReadData1 !== e.e1) begin
                n_bad++;
                $display("FAIL %s port1: got %h expected %h", e.name, ReadData1, e.e1);
            end
            n_vec++;
            if (ReadData2 !== e.e2) begin
                n_bad++;
                $display("FAIL %s port2: got %h expected %h", e.name, ReadData2, e.e2);
            end
        end
    end

    task automatic cyc(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [63:0] e1, input logic [63:0] e2, input string name);
        exp_t e;
        reset         = rst;
        RegWrite      = we;
        WriteRegister = wr;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        e.e1   = e1;
        e.e2   = e2;
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(1, 1, 5, 64'hDEAD, 5, 5, 0, 0, "reset_hold0");
        cyc(1, 1, 5, 64'hDEAD, 5, 5, 0, 0, "reset_hold1");
        cyc(0, 0, 5, 64'h0,    5, 5, 0, 0, "post_reset_x5");
        for (int i = 0; i < 31; i++)
            cyc(0, 1, 5'(i), 64'h1000 + 64'(i), 5'(i), 5'd31, 64'h1000 + 64'(i), 0, "write_bypass");
        for (int i = 0; i < 31; i++)
            cyc(0, 0, 0, 0, 5'(i), 5'(30 - i), 64'h1000 + 64'(i), 64'h1000 + 64'(30 - i), "readback_pair");
        cyc(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, 0, 0, "xzr_write_cycle");
        cyc(0, 0, 31, 64'h0, 31, 31, 0, 0, "xzr_after");
        cyc(0, 1, 7, 64'h11, 0, 7, 64'h1000, 64'h11, "bypass_setup");
        cyc(0, 1, 7, 64'h22, 7, 7, 64'h22, 64'h22, "bypass_both");
        cyc(0, 0, 7, 64'h0,  7, 7, 64'h22, 64'h22, "bypass_stored");
        cyc(0, 0, 3, 64'hBEEF, 3, 3, 64'h1003, 64'h1003, "nowrite_cycle");
        cyc(0, 0, 0, 64'h0,    3, 3, 64'h1003, 64'h1003, "nowrite_after");
        cyc(0, 1, 1, 64'hAA, 1, 2, 64'hAA, 64'h1002, "mid_write_x1");
        cyc(1, 1, 2, 64'hBB, 1, 2, 0, 0, "mid_reset");
        cyc(0, 0, 0, 64'h0,  1, 2, 0, 0, "mid_after_x1_x2");
        cyc(0, 0, 0, 64'h0,  5, 30, 0, 0, "mid_after_x5_x30");
        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
